// File: rtl/four_bank_mem_pkg.sv
// Shared constants for the four-bank interleaved main-memory model.
package four_bank_mem_pkg;

   localparam int unsigned NUM_BANKS     = 4;
   localparam int unsigned BANK_W        = 2;
   localparam int unsigned ROW_W         = 13;
   localparam int unsigned DATA_W        = 16;
   localparam int unsigned RD_LAT_DEF    = 2;
   localparam int unsigned BANK_BUSY_DEF = 4;

   // Bank select lives in offset_m[2:1]; offset_m[0] must be zero.
   localparam int unsigned BANK_LSB      = 1;
   localparam int unsigned BANK_MSB      = 2;

endpackage

// File: rtl/mem_bank.sv
// One 8K x 16 word bank: write port, registered read and busy down-counter.
module mem_bank
   import four_bank_mem_pkg::*;
#(
   parameter int unsigned BANK_BUSY = BANK_BUSY_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ROW_W-1:0]  row,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;

   logic [DATA_W-1:0] mem_q [2**ROW_W];
   logic [CNT_W-1:0]  cnt_q;

   // Storage and read register; array contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[row] <= wdata;
      end
      if (re) begin
         rdata <= mem_q[row];
      end
   end

   // Occupancy counter: loaded on any access, counts down to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (we || re) begin
         cnt_q <= CNT_W'(BANK_BUSY - 1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Word-interleaved main memory behind the cache controller: decode, arbitration
// and the fixed-latency read return pipeline.
module four_bank_mem
   import four_bank_mem_pkg::*;
#(
   parameter int unsigned RD_LAT    = RD_LAT_DEF,
   parameter int unsigned BANK_BUSY = BANK_BUSY_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_m,
   input  logic                 rd_m,
   input  logic [4:0]           tag_m,
   input  logic [7:0]           index,
   input  logic [2:0]           offset_m,
   input  logic [DATA_W-1:0]    data_in_m,
   output logic [DATA_W-1:0]    data_out_m,
   output logic                 data_valid_m,
   output logic                 stall_m,
   output logic [NUM_BANKS-1:0] busy,
   output logic                 err
);

   logic [BANK_W-1:0]    bank;
   logic [ROW_W-1:0]     row;
   logic                 req;
   logic                 acc;
   logic [NUM_BANKS-1:0] bank_we;
   logic [NUM_BANKS-1:0] bank_re;
   logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

   // vld_q[0] marks a bank read register holding fresh data; later stages
   // line up with dpipe_q of the same index.
   logic [RD_LAT-1:0]    vld_q;
   logic [BANK_W-1:0]    sel_q;
   logic [DATA_W-1:0]    dpipe_q [RD_LAT-1:1];

   assign bank = offset_m[BANK_MSB:BANK_LSB];
   assign row  = {tag_m, index};
   assign req  = rd_m | wr_m;

   // Request classification; rst only blocks acceptance, not the flags.
   always_comb begin
      err     = (rd_m & wr_m) | (req & offset_m[0]);
      stall_m = req & ~err & busy[bank];
      acc     = req & ~err & ~busy[bank] & ~rst;
   end

   // Steer an accepted request to its bank.
   always_comb begin
      bank_we = '0;
      bank_re = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank == BANK_W'(b)) begin
            bank_we[b] = acc & wr_m;
            bank_re[b] = acc & rd_m;
         end
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      mem_bank #(
         .BANK_BUSY (BANK_BUSY)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (bank_we[g]),
         .re    (bank_re[g]),
         .row   (row),
         .wdata (data_in_m),
         .rdata (bank_rdata[g]),
         .busy  (busy[g])
      );
   end

   // Read return pipeline: remember the bank, mux its read one cycle later,
   // then delay to RD_LAT. Invalid slots carry zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         sel_q <= '0;
         for (int k = 1; k < RD_LAT; k++) begin
            dpipe_q[k] <= '0;
         end
      end else begin
         vld_q      <= {vld_q[RD_LAT-2:0], acc & rd_m};
         sel_q      <= bank;
         dpipe_q[1] <= vld_q[0] ? bank_rdata[sel_q] : '0;
         for (int k = 2; k < RD_LAT; k++) begin
            dpipe_q[k] <= dpipe_q[k-1];
         end
      end
   end

   assign data_out_m   = dpipe_q[RD_LAT-1];
   assign data_valid_m = vld_q[RD_LAT-1];

endmodule
